irq_controller4: RTL

//  4-line interrupt controller for the MIPS core. Detects rising edges on external IRQ lines,

---
 rtl/irq_pkg.sv | 19 +
 rtl/priority_encoder4X2.sv | 15 +
 rtl/irq_controller4.sv | 86 ++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the 4-line interrupt controller: sizes, FSM encoding,
// and the vector-to-clear-mask helper.
package irq_pkg;
  localparam int N_IRQ = 4;
  localparam int VEC_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

  function automatic logic [N_IRQ-1:0] onehot(input logic [VEC_W-1:0] idx);
    logic [N_IRQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/priority_encoder4X2.sv
// 4:2 priority encoder, bit 3 highest. out is forced to 0 when nothing is set;
// callers gate on z and never rely on that value.
module priority_encoder4X2 (
  input  logic [3:0] in,
  output logic [1:0] out,
  output logic       z
);
  always_comb begin
    out = 2'd0;
    if (in[3])      out = 2'd3;
    else if (in[2]) out = 2'd2;
    else if (in[1]) out = 2'd1;
    z = |in;
  end
endmodule

// File: rtl/irq_controller4.sv
// 4-line edge-triggered interrupt controller with mask, priority select and
// a req/ack/eoi handshake toward the CPU.
//
// state | meaning
// IDLE  | no request outstanding; commits highest masked pending line
// REQ   | int_req high with committed vector, waiting for int_ack
// SVC   | CPU servicing; new edges still pend, waiting for eoi
module irq_controller4
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic [N_IRQ-1:0] mask_q,
  output logic [N_IRQ-1:0] pending,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  input  logic             int_ack,
  output logic             in_service,
  input  logic             eoi
);
  state_t           state;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] masked;
  logic [N_IRQ-1:0] clr;
  logic [VEC_W-1:0] vec_r;
  logic [VEC_W-1:0] enc_out;
  logic             enc_z;

  assign rise    = irq_in & ~irq_prev;
  assign masked  = pending & mask_q;
  assign int_vec = vec_r;

  // Only an accepted request clears its pending bit; a same-cycle edge on
  // that line re-sets it because rise is OR-ed in after the clear.
  always_comb begin
    clr = '0;
    if (state == S_REQ && int_ack) clr = onehot(vec_r);
  end

  priority_encoder4X2 u_enc (
    .in  (masked),
    .out (enc_out),
    .z   (enc_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev   <= '0;
      pending    <= '0;
      mask_q     <= '0;
      vec_r      <= '0;
      state      <= S_IDLE;
      int_req    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      pending  <= (pending & ~clr) | rise;
      if (mask_we) mask_q <= mask_wdata;
      case (state)
        S_IDLE: if (enc_z) begin
          vec_r   <= enc_out;
          state   <= S_REQ;
          int_req <= 1'b1;
        end
        S_REQ: if (int_ack) begin
          state      <= S_SVC;
          int_req    <= 1'b0;
          in_service <= 1'b1;
        end
        S_SVC: if (eoi) begin
          state      <= S_IDLE;
          in_service <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end
endmodule
